fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front end between the core's PC/redirect logic and the instruction SRAM on the fetch clock. It drives the SRAM word address and captures the 1-cycle-latency read data. It buffers instruction/PC pairs in a small FIFO and hands them to decode over a valid/ready handshake. It squashes everything on redirect and stops fetching after the last program PC.

## Interface
- CACHE_WIDTHE, 5: log2 of instruction width; width = 2**CACHE_WIDTHE = 32.
- CACHE_DEEPTHE, 12: SRAM address width in words.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- RESET_PC, 32'h0: byte PC fetched first after reset.
- LAST_PC, 32'h2b4: byte PC of the final instruction; fetch halts after issuing it.

Ports:
- clk  in  1  fetch clock (the same clock as the instruction SRAM).
- rst  in  1  reset, synchronous, active-high.
- InsAddr  out  CACHE_DEEPTHE  SRAM word address = FetchPc[CACHE_DEEPTHE+1:2].
- InsData  in  32  SRAM read data; valid the cycle after the address is sampled.
- Redirect  in  1  flush and restart fetch.
- RedirectPc  in  32  new byte PC; bits [1:0] ignored and forced to 0.
- OutValid  out  1  FIFO head valid.
- OutReady  in  1  decode accepts the head.
- OutIns  out  32  head instruction.
- OutPc  out  32  head byte PC.
- Done  out  1  halted, nothing in flight, FIFO empty.

## Operation
- State:
  - FetchPc (32).
  - Inflight flag plus InflightPc.
  - Halted flag.
  - FIFO with rd/wr pointers and count.
- Issue condition: !Halted && (count + Inflight) < DEPTH.
  - The pop in the same cycle is not credited.
  - On issue: Inflight <= 1, InflightPc <= FetchPc, FetchPc <= FetchPc + 4 (mod 2^32). If FetchPc == LAST_PC, also Halted <= 1.
  - No issue: Inflight <= 0, and FetchPc holds.
  - InsAddr always reflects FetchPc; the SRAM reads every cycle, and only issued cycles are tracked.
- Capture: when Inflight == 1, push {InsData, InflightPc} into the FIFO at the edge.
- Pop: when OutValid && OutReady, advance the read pointer. A push and a pop in the same cycle leave count unchanged.
- No bypass: a pushed entry is visible at the head no earlier than the next cycle.
- Redirect (highest priority, at the edge):
  - FIFO cleared (pointers and count reset to 0).
  - Inflight <= 0; the returning data is dropped and not pushed.
  - Halted <= 0.
  - FetchPc <= {RedirectPc[31:2], 2'b00}.
  - No issue occurs in the redirect cycle.
  - An OutValid && OutReady in the same cycle still counts as accepted by decode.
- Done = Halted && !Inflight && count == 0, combinational from registers.
- Pointer wrap is modulo DEPTH; count ranges 0..DEPTH. The credit rule means push-while-full cannot happen; an assertion checks this.

## Timing
- Reset values:
  - FetchPc = RESET_PC, Inflight = 0, Halted = 0, count = 0.
  - OutValid = 0, Done = 0, InsAddr = RESET_PC[CACHE_DEEPTHE+1:2].
  - OutIns and OutPc read the FIFO head; don't-care while OutValid = 0.
- Issue-to-output latency is 2 edges. An address issued in cycle k has data arriving in cycle k+1, is pushed at edge k+2, and raises OutValid in cycle k+2.
- Redirect asserted in cycle r: InsAddr = RedirectPc in cycle r+1, first OutValid in cycle r+3.
- Throughput is 1 instruction/cycle with OutReady held high and DEPTH ≥ 2.
- Reset asserted mid-operation overrides Redirect and all state at that edge.

## Structure
- Package fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] Ins; logic [31:0] Pc;}
  - localparam INS_BYTES = 4.
- Sub-module sync_fifo:
  - Parameterised on type/width and DEPTH.
  - Ports: clk, rst, Clear, Push, PushData, Pop, HeadData, Count.
- fetch_queue holds the PC, inflight, halt and credit logic.

## Test plan
- Reset, RESET_PC=0, OutReady=1: OutValid rises in cycle 2 with OutPc=0, OutIns=mem[0]. Then one instruction per cycle, PCs 0,4,8,…
- OutReady=0 from reset, DEPTH=4: exactly 4 entries (PCs 0,4,8,12) captured. InsAddr holds at word 4, and there is no issue while count+Inflight=4. Releasing OutReady drains in order, then fetching resumes at PC 16.
- Redirect to 32'h102 while FIFO holds 3 entries and one is in flight:
  - Next cycle OutValid=0 and InsAddr=0x40.
  - The old inflight data is never output.
  - The first output is OutPc=0x100, 3 cycles after the Redirect cycle.
- Run to LAST_PC=0x2b4:
  - The final output has OutPc=0x2b4, and no PC 0x2b8 is ever output.
  - Done=1 once it is popped.
  - A Redirect to 0 clears Done and restarts fetch.
- Redirect and OutValid&&OutReady in the same cycle: the head is consumed, all else is flushed, and no duplicate PC follows.
- rst asserted for one cycle mid-stream with Redirect also high: all state returns to reset values, and the next output is OutPc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   fetch_entry_t : one buffered instruction with the byte PC it was fetched from.
//   INS_BYTES     : byte stride between consecutive instructions.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] Ins;
        logic [31:0] Pc;
    } fetch_entry_t;

    localparam int INS_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear. Power-of-two DEPTH.
// The head is read straight from storage, so a pushed entry shows up at
// the head one cycle after the push edge at the earliest. There is no bypass.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   Clear      empty the FIFO at the edge (wins over Push/Pop)
//   Push       write PushData at the tail
//   PushData   entry to write
//   Pop        advance the head (ignored while empty)
//   HeadData   entry at the head (don't-care while Count == 0)
//   Count      occupancy, 0..DEPTH
module sync_fifo
    import fetch_pkg::*;
#(
    parameter type T         = fetch_entry_t,
    parameter int  DEPTH     = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Clear,
    input  logic          Push,
    input  T              PushData,
    input  logic          Pop,
    output T              HeadData,
    output logic [CW-1:0] Count
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = Pop && (r_count != '0);
    assign w_push = Push && !Clear && !rst;

    // Storage is kept out of the reset path so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= PushData;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || Clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (Push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            if (Push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!Push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // The producer only issues against free credit, so pushing into a full
    // FIFO means the credit accounting upstream is broken.
    always_ff @(posedge clk) begin
        if (w_push)
            assert (r_count < CW'(DEPTH));
    end

    assign HeadData = r_mem[r_rd];
    assign Count    = r_count;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end. Drives the SRAM word address
// from FetchPc, tracks the one issued read in flight (1-cycle SRAM latency),
// buffers {instruction, PC} pairs in a FIFO and hands them to decode over
// a valid/ready handshake. Redirect squashes everything and restarts at a new
// PC. Fetch stops after LAST_PC is issued.
// Ports:
//   clk, rst     fetch clock (shared with the SRAM), synchronous active-high reset
//   InsAddr      SRAM word address (FetchPc without the byte offset)
//   InsData      SRAM read data, valid the cycle after the address
//   Redirect     flush and restart at RedirectPc (byte PC, low 2 bits ignored)
//   OutValid     FIFO head valid
//   OutReady     decode accepts the head
//   OutIns       head instruction
//   OutPc        head byte PC
//   Done         halted, nothing in flight and FIFO empty
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          CACHE_WIDTHE  = 5,
    parameter int          CACHE_DEEPTHE = 12,
    parameter int          DEPTH         = 4,
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter logic [31:0] LAST_PC       = 32'h2b4,
    localparam int         INS_W         = 1 << CACHE_WIDTHE
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [CACHE_DEEPTHE-1:0] InsAddr,
    input  logic [INS_W-1:0]         InsData,
    input  logic                     Redirect,
    input  logic [31:0]              RedirectPc,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [31:0]              OutIns,
    output logic [31:0]              OutPc,
    output logic                     Done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_inflight_pc;
    logic         r_inflight;
    logic         r_halted;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;

    // Credit: entries held plus the read in flight must leave a free slot.
    // A pop this cycle is deliberately not credited, which keeps the issue
    // decision off the decode ready path.
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = !r_halted && !Redirect && (w_occ < (CW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_halted      <= 1'b0;
        end else if (Redirect) begin
            // Returning data for the squashed read is dropped by clearing r_inflight.
            r_fetch_pc <= RedirectPc & 32'hFFFF_FFFC;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'(INS_BYTES);
                if (r_fetch_pc == LAST_PC)
                    r_halted <= 1'b1;
            end
        end
    end

    // The SRAM reads every cycle; only issued cycles are captured.
    assign InsAddr         = r_fetch_pc[CACHE_DEEPTHE+1:2];
    assign w_push          = r_inflight && !Redirect;
    assign w_push_data.Ins = InsData;
    assign w_push_data.Pc  = r_inflight_pc;
    assign w_pop           = OutValid && OutReady;

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .Clear    (Redirect),
        .Push     (w_push),
        .PushData (w_push_data),
        .Pop      (w_pop),
        .HeadData (w_head),
        .Count    (w_count)
    );

    assign OutValid = (w_count != '0);
    assign OutIns   = w_head.Ins;
    assign OutPc    = w_head.Pc;
    assign Done     = r_halted && !r_inflight && (w_count == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a queue-based
// reference model checked every cycle, plus hand-computed literal checks.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] LAST_PC  = 32'h2b4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] InsAddr;
    logic [31:0] InsData = '0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPc = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutIns;
    logic [31:0] OutPc;
    logic        Done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .CACHE_WIDTHE  (5),
        .CACHE_DEEPTHE (12),
        .DEPTH         (DEPTH),
        .RESET_PC      (RESET_PC),
        .LAST_PC       (LAST_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .InsAddr    (InsAddr),
        .InsData    (InsData),
        .Redirect   (Redirect),
        .RedirectPc (RedirectPc),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutIns     (OutIns),
        .OutPc      (OutPc),
        .Done       (Done)
    );

    // Instruction memory contents: unique per word.
    function automatic logic [31:0] memf(input logic [11:0] w);
        return {20'hC0DE0, w};
    endfunction

    function automatic logic [31:0] memp(input logic [31:0] pc);
        return memf(pc[13:2]);
    endfunction

    // 1-cycle-latency SRAM.
    always @(posedge clk) InsData <= memf(InsAddr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: queue of buffered PCs, the PC in flight, the next PC.
    logic [31:0] m_q [$];
    logic [31:0] m_fpc = RESET_PC;
    logic [31:0] m_infpc = '0;
    bit          m_inf  = 1'b0;
    bit          m_halt = 1'b0;
    bit          m_iss;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_fpc  = RESET_PC;
            m_inf  = 1'b0;
            m_halt = 1'b0;
        end else if (Redirect) begin
            m_q.delete();
            m_inf  = 1'b0;
            m_halt = 1'b0;
            m_fpc  = {RedirectPc[31:2], 2'b00};
        end else begin
            m_iss = !m_halt && ((m_q.size() + int'(m_inf)) < DEPTH);
            if (OutReady && m_q.size() > 0)
                void'(m_q.pop_front());
            if (m_inf)
                m_q.push_back(m_infpc);
            m_inf = m_iss;
            if (m_iss) begin
                m_infpc = m_fpc;
                if (m_fpc == LAST_PC)
                    m_halt = 1'b1;
                m_fpc = m_fpc + 32'd4;
            end
        end
    end

    // Log of PCs accepted by decode, taken from the DUT handshake.
    logic [31:0] acc [$];

    function automatic logic [31:0] accat(input int i);
        if (i >= 0 && i < acc.size())
            return acc[i];
        return 32'hFFFF_FFFF;
    endfunction

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", {31'b0, OutValid}, {31'b0, m_q.size() > 0});
            if (m_q.size() > 0) begin
                chk("outpc", OutPc, m_q[0]);
                chk("outins", OutIns, memp(m_q[0]));
            end
            chk("insaddr", {20'b0, InsAddr}, {20'b0, m_fpc[13:2]});
            chk("done", {31'b0, Done}, {31'b0, m_halt && !m_inf && m_q.size() == 0});
            if (OutValid && OutReady)
                acc.push_back(OutPc);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst low).
    task automatic do_reset(input bit rdy);
        rst      = 1'b1;
        Redirect = 1'b0;
        OutReady = rdy;
        tick(2);
        rst = 1'b0;
    endtask

    int          a0;
    int          bad;
    logic [31:0] h;

    initial begin
        // 1: streaming from reset
        do_reset(1'b1);
        chk("t1 reset valid", {31'b0, OutValid}, 32'd0);
        chk("t1 reset addr", {20'b0, InsAddr}, 32'd0);
        chk("t1 reset done", {31'b0, Done}, 32'd0);
        tick();
        chk("t1 c1 valid", {31'b0, OutValid}, 32'd0);
        tick();
        chk("t1 c2 valid", {31'b0, OutValid}, 32'd1);
        chk("t1 c2 pc", OutPc, 32'h0);
        chk("t1 c2 ins", OutIns, 32'hC0DE_0000);
        tick();
        chk("t1 c3 pc", OutPc, 32'h4);
        chk("t1 c3 ins", OutIns, 32'hC0DE_0001);
        tick();
        chk("t1 c4 pc", OutPc, 32'h8);
        tick(5);

        // 2: stalled decode fills exactly DEPTH entries, then drains in order
        do_reset(1'b0);
        tick(6);
        chk("t2 full valid", {31'b0, OutValid}, 32'd1);
        chk("t2 full head", OutPc, 32'h0);
        chk("t2 addr hold", {20'b0, InsAddr}, 32'd4);
        tick(4);
        chk("t2 addr hold2", {20'b0, InsAddr}, 32'd4);
        a0 = acc.size();
        OutReady = 1'b1;
        tick(12);
        for (int i = 0; i < 6; i++)
            chk("t2 drain order", accat(a0 + i), 32'(4 * i));

        // 3: redirect with 3 buffered and 1 in flight
        do_reset(1'b0);
        tick(4);
        Redirect   = 1'b1;
        RedirectPc = 32'h102;
        tick();
        Redirect = 1'b0;
        chk("t3 r1 valid", {31'b0, OutValid}, 32'd0);
        chk("t3 r1 addr", {20'b0, InsAddr}, 32'h40);
        a0 = acc.size();
        tick();
        chk("t3 r2 valid", {31'b0, OutValid}, 32'd0);
        tick();
        chk("t3 r3 valid", {31'b0, OutValid}, 32'd1);
        chk("t3 r3 pc", OutPc, 32'h100);
        OutReady = 1'b1;
        tick(6);
        chk("t3 first out", accat(a0), 32'h100);
        bad = 0;
        for (int i = a0; i < acc.size(); i++)
            if (acc[i] < 32'h100) bad++;
        chk("t3 no stale", 32'(bad), 32'd0);

        // 4: run to LAST_PC and halt
        Redirect   = 1'b1;
        RedirectPc = 32'h280;
        tick();
        Redirect = 1'b0;
        a0 = acc.size();
        tick(30);
        chk("t4 done", {31'b0, Done}, 32'd1);
        chk("t4 idle", {31'b0, OutValid}, 32'd0);
        chk("t4 count", 32'(acc.size() - a0), 32'd14);
        chk("t4 last pc", accat(acc.size() - 1), 32'h2b4);
        bad = 0;
        foreach (acc[i])
            if (acc[i] == 32'h2b8) bad++;
        chk("t4 no 2b8", 32'(bad), 32'd0);
        Redirect   = 1'b1;
        RedirectPc = 32'h0;
        tick();
        Redirect = 1'b0;
        chk("t4 restart done", {31'b0, Done}, 32'd0);
        chk("t4 restart addr", {20'b0, InsAddr}, 32'd0);
        tick(3);

        // 5: redirect in the same cycle as a handshake
        tick(3);
        chk("t5 streaming", {31'b0, OutValid}, 32'd1);
        h  = OutPc;
        a0 = acc.size();
        Redirect   = 1'b1;
        RedirectPc = 32'h200;
        tick();
        Redirect = 1'b0;
        tick(5);
        chk("t5 head taken", accat(a0), h);
        chk("t5 next is target", accat(a0 + 1), 32'h200);

        // 6: reset mid-stream overrides a simultaneous redirect
        tick(4);
        rst        = 1'b1;
        Redirect   = 1'b1;
        RedirectPc = 32'h300;
        tick();
        rst      = 1'b0;
        Redirect = 1'b0;
        chk("t6 valid", {31'b0, OutValid}, 32'd0);
        chk("t6 addr", {20'b0, InsAddr}, 32'd0);
        chk("t6 done", {31'b0, Done}, 32'd0);
        tick();
        chk("t6 c1 valid", {31'b0, OutValid}, 32'd0);
        tick();
        chk("t6 c2 valid", {31'b0, OutValid}, 32'd1);
        chk("t6 c2 pc", OutPc, RESET_PC);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
